mux16_rr_sched: RTL
===================

Name: mux16_rr_sched

Overview:
- Round-robin scheduler that shares one 16:1 mux datapath among 16 requesters.
- Produces the 4-bit mux select plus a one-hot grant, holds each grant until the requester signals done, drops its request, or hits a hold-time limit.
- Inserts one idle (GAP) cycle between grants so downstream logic sees a clean select change.
- Sits directly in front of the 16:1 mux; `sel` drives the mux select bus.

Parameters:
- N_REQ, 16: number of requesters; fixed at 16 for this revision.
- SEL_W, 4: select width, equal to log2(N_REQ).
- MAX_HOLD, 8: maximum GRANT cycles per grant before forced release; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- en  input  1  1 = new grants allowed; 0 = no new grants, but a grant already in progress runs to completion.
- req  input  16  request vector; bit i = requester i wants the mux.
- done  input  1  granted requester has finished; sampled only in GRANT.
- sel  output  4  mux select, registered; equals the index of the granted requester.
- grant  output  16  one-hot grant, registered; all zero outside GRANT.
- grant_valid  output  1  high exactly while in GRANT.
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, sel=0, grant=0, grant_valid=0, timeout=0.
  - hold counter=0, priority pointer last=15, so requester 0 has first priority.
- States: IDLE, GRANT, GAP. All outputs are registered.
- Arbitration, evaluated in IDLE:
  - If en=1 and req!=0, pick the first set req bit searching last+1, last+2, … with wrap 15→0.
  - Next cycle: state=GRANT, sel=winner, grant=1<<winner, grant_valid=1, last=winner, counter=0.
  - Latency from req to grant is one cycle.
  - If en=0 or req=0, stay in IDLE; sel keeps its previous value.
- GRANT:
  - The counter increments each cycle.
  - Release conditions, in priority order:
    - done=1: normal release.
    - req[sel]=0: abandoned; normal release, no timeout.
    - counter==MAX_HOLD-1: forced release; timeout=1 on the following cycle, coincident with the first GAP cycle.
  - done and the timeout condition in the same cycle: done wins, no timeout pulse.
  - On release, next state is GAP: grant=0, grant_valid=0, sel holds its value.
  - Grant length therefore lies in 1..MAX_HOLD cycles.
- GAP:
  - Lasts exactly one cycle, then IDLE.
  - The released requester has lowest priority in the next arbitration (pointer already advanced), so a persistent requester is regranted only if no other request is pending.
- en deasserted during GRANT does not shorten the grant; it only blocks the next arbitration.
- req bits other than sel are ignored during GRANT and GAP.
- done outside GRANT is ignored.
- timeout is never high for more than one cycle, and never high in GRANT.
- Reset asserted mid-GRANT clears all outputs asynchronously. No timeout pulse is generated, and the pointer returns to 15.

Test Plan:
- Reset check: assert rst mid-simulation → sel=0, grant=0, grant_valid=0, timeout=0 immediately, without waiting for a clock edge.
- Single grant: req=0x0001, en=1 → next cycle grant=0x0001, sel=0, grant_valid=1; done pulsed on the 3rd GRANT cycle → one GAP cycle with grant_valid=0, then IDLE.
- Round robin: req=0x8421 held, done=1 every GRANT cycle → sel sequence 0,5,10,15,0, with a GAP cycle between each grant.
- Timeout: MAX_HOLD=8, req=0x0008 held, done=0 → grant=0x0008 for exactly 8 cycles; timeout=1 for one cycle in the GAP; sole requester 3 is regranted after IDLE.
- Abandon and tie: req[sel] dropped on the 2nd GRANT cycle → release with no timeout pulse. done and counter==MAX_HOLD-1 in the same cycle → no timeout pulse.
- Enable gating: en=0 with req=0xFFFF → grant_valid stays 0. en dropped mid-grant → current grant runs until done, then the block stays in IDLE.

Source files
------------

// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler for a shared 16:1 mux: one-hot grant plus registered select,
// bounded hold time and a single idle cycle between consecutive grants.
module mux16_rr_sched #(
  parameter int unsigned N_REQ    = 16,
  parameter int unsigned SEL_W    = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid,
  output logic             timeout
);

  localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

  typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               grant_valid_q, grant_valid_d;
  logic               timeout_q, timeout_d;
  logic [7:0]         cnt_q, cnt_d;

  logic               found;
  logic [SEL_W-1:0]   win;
  logic [SEL_W-1:0]   idx;

  // Search starts just after the last winner; the select width wraps 15 -> 0 naturally.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = last_q + SEL_W'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    grant_d       = '0;
    grant_valid_d = 1'b0;
    timeout_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (en && found) begin
          state_d       = StGrant;
          sel_d         = win;
          grant_d       = N_REQ'(1) << win;
          grant_valid_d = 1'b1;
          last_d        = win;
          cnt_d         = '0;
        end
      end
      StGrant: begin
        cnt_d = cnt_q + 8'd1;
        if (done || !req[sel_q]) begin
          state_d = StGap;
        end else if (cnt_q == HoldLast) begin
          state_d   = StGap;
          timeout_d = 1'b1;
        end else begin
          grant_d       = grant_q;
          grant_valid_d = 1'b1;
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      sel_q         <= '0;
      last_q        <= '1;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      last_q        <= last_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      timeout_q     <= timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  assign sel         = sel_q;
  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign timeout     = timeout_q;

endmodule
